serial_parallel_rx: RTL

Serial-to-parallel receiver; the far end of the byte serializer link.
- Samples one bit per CLK (MSB first) and finds byte alignment by hunting for the COM symbol.
- Locks after LOCK_COUNT consecutive aligned COMs, then delivers each non-COM byte with a one-cycle valid strobe.
- Sits at the receive side of the lane, feeding byte-wide logic downstream.

---
 rtl/serial_pkg.sv | 8 +
 rtl/sp_com_detect.sv | 21 ++
 rtl/serial_parallel_rx.sv | 102 ++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// serial_pkg: symbols and FSM state encoding shared by the serial link transmit and receive ends.
package serial_pkg;
    localparam logic [7:0] COM_SYM = 8'hBC;
    typedef logic [1:0] state_t;
    localparam state_t SEARCH = 2'd0;
    localparam state_t ALIGN  = 2'd1;
    localparam state_t ACTIVE = 2'd2;
endpackage

// File: rtl/sp_com_detect.sv
// sp_com_detect: serial shift window with a comparator against the COM symbol, MSB first.
module sp_com_detect
    import serial_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter logic [WIDTH-1:0] COM = WIDTH'(COM_SYM)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             bit_i,
    output logic [WIDTH-1:0] win_o,
    output logic             is_com_o
);
    logic [WIDTH-2:0] shift_q;
    assign win_o = {shift_q, bit_i};
    assign is_com_o = win_o == COM;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) shift_q <= '0;
        else shift_q <= win_o[WIDTH-2:0];
    end
endmodule

// File: rtl/serial_parallel_rx.sv
// serial_parallel_rx: bit-serial receiver that hunts for COM, locks after LOCK_COUNT aligned COMs and strobes data bytes.
// Defining RX_LOSS_DETECT_EN adds MAX_GAP and drops lock after too many bytes without a COM.
module serial_parallel_rx
    import serial_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter logic [WIDTH-1:0] COM = WIDTH'(COM_SYM),
    parameter int LOCK_COUNT = 4
`ifdef RX_LOSS_DETECT_EN
    , parameter int MAX_GAP = 64
`endif
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             DATA_IN,
    output logic [WIDTH-1:0] DATA_OUT,
    output logic             Valid_out,
    output logic             active
);
    localparam int CW = $clog2(LOCK_COUNT + 1);
    localparam int BW = $clog2(WIDTH);
    logic [WIDTH-1:0] win, data_q, data_d;
    logic             is_com, valid_q, valid_d, active_q, active_d, done;
    state_t           state_q, state_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [CW-1:0]    com_q, com_d, com_inc;
    sp_com_detect #(.WIDTH(WIDTH), .COM(COM)) u_det (
        .clk_i(CLK), .rst_ni(RESET), .bit_i(DATA_IN), .win_o(win), .is_com_o(is_com)
    );
    assign done = bit_q == BW'(WIDTH - 1);
    assign com_inc = com_q == CW'(LOCK_COUNT) ? com_q : com_q + 1'b1;
`ifdef RX_LOSS_DETECT_EN
    localparam int GW = $clog2(MAX_GAP + 1);
    logic [GW-1:0] gap_q, gap_d;
    logic          gap_hit;
    assign gap_hit = gap_q == GW'(MAX_GAP);
    assign gap_d = (state_q != ACTIVE || (done && (is_com || gap_hit))) ? '0 : done ? gap_q + 1'b1 : gap_q;
`endif
    always_comb begin
        state_d = state_q;
        bit_d = (state_q == SEARCH || done) ? '0 : bit_q + 1'b1;
        com_d = com_q;
        data_d = data_q;
        valid_d = 1'b0;
        active_d = active_q;
        if (state_q == SEARCH) begin
            if (is_com) begin
                com_d = CW'(1);
                state_d = LOCK_COUNT == 1 ? ACTIVE : ALIGN;
                active_d = LOCK_COUNT == 1;
            end
        end else if (done && state_q == ALIGN) begin
            // A misaligned boundary restarts the hunt on the following edge.
            if (!is_com) begin
                state_d = SEARCH;
                com_d = '0;
            end else begin
                com_d = com_inc;
                if (com_inc == CW'(LOCK_COUNT)) begin
                    state_d = ACTIVE;
                    active_d = 1'b1;
                end
            end
        end else if (done && state_q == ACTIVE && !is_com) begin
            data_d = win;
            valid_d = 1'b1;
`ifdef RX_LOSS_DETECT_EN
            if (gap_hit) begin
                state_d = SEARCH;
                active_d = 1'b0;
                com_d = '0;
            end
`endif
        end
    end
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= SEARCH;
            bit_q <= '0;
            com_q <= '0;
            data_q <= '0;
            valid_q <= 1'b0;
            active_q <= 1'b0;
`ifdef RX_LOSS_DETECT_EN
            gap_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            bit_q <= bit_d;
            com_q <= com_d;
            data_q <= data_d;
            valid_q <= valid_d;
            active_q <= active_d;
`ifdef RX_LOSS_DETECT_EN
            gap_q <= gap_d;
`endif
        end
    end
    assign DATA_OUT = data_q;
    assign Valid_out = valid_q;
    assign active = active_q;
endmodule
